// File: rtl/adder_pkg.sv
// Shared constants and entry layout for the 32-bit two-stage adder and its
// response buffer.
package adder_pkg;

    localparam int ADDER_DW        = 32;
    localparam int ADDER_LAT       = 2;
    localparam int ADDER_RSP_DEPTH = 4;
    localparam int ADDER_RSP_EW    = ADDER_DW + 1;

    // FIFO entry layout: overflow flag above the sum.
    typedef struct packed {
        logic                ovf;
        logic [ADDER_DW-1:0] data;
    } adder_rsp_entry_t;

    // Results still owed to the FIFO: a stage-1 tag, plus a stage-2 tag not yet captured.
    function automatic logic [1:0] inflight_cnt(input logic v1, input logic v2, input logic cap);
        return {1'b0, v1} + {1'b0, v2 & ~cap};
    endfunction

endpackage

// File: rtl/adder_rsp_fifo.sv
// Synchronous FIFO holding captured adder results; the producer is
// credit-throttled, so there is no full/drop handling.
module adder_rsp_fifo
    import adder_pkg::*;
#(
    parameter int DEPTH = ADDER_RSP_DEPTH,
    parameter int W     = ADDER_RSP_EW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           wdata,
    output logic [W-1:0]           rdata,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic [AW:0]   count_nxt_s;
    logic          empty_r;

    // Occupancy update; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_nxt_s = count_r;
        case ({push, pop})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Storage, pointers and occupancy; reset clears storage so the head reads zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            empty_r  <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_nxt_s;
            empty_r <= (count_nxt_s == '0);
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign empty = empty_r;
    assign count = count_r;

endmodule

// File: rtl/adder_rsp_buf.sv
// Response stage for the two-stage adder: slot tags, one-shot capture, credit
// issue control. Define ADDER_RSP_OVF_CNT_EN to add the ovf_cnt counter port.
module adder_rsp_buf
    import adder_pkg::*;
#(
    parameter int DEPTH = ADDER_RSP_DEPTH,
    parameter int DW    = ADDER_DW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   adder_en,
    input  logic                   adder_clr,
    input  logic                   issue_vld,
    output logic                   issue_rdy,
    input  logic [DW-1:0]          add_out,
    input  logic                   add_ovf,
    output logic                   rsp_vld,
    input  logic                   rsp_rdy,
    output logic [DW-1:0]          rsp_data,
    output logic                   rsp_ovf,
`ifdef ADDER_RSP_OVF_CNT_EN
    output logic [15:0]            ovf_cnt,
`endif
    output logic [$clog2(DEPTH):0] level
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    logic          v1_r;
    logic          v2_r;
    logic          cap_r;
    logic          accept_s;
    logic          push_s;
    logic          pop_s;
    logic [1:0]    inflight_s;
    logic [CW:0]   credit_used_s;
    logic [DW:0]   wdata_s;
    logic [DW:0]   rdata_s;
    logic          empty_s;
    logic [CW-1:0] count_s;

    assign accept_s = issue_vld & issue_rdy & adder_en;
    assign push_s   = v2_r & ~cap_r;
    assign pop_s    = rsp_vld & rsp_rdy;

    // Slot tags follow the adder stages; a clear empties both and drops this cycle's issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_r <= 1'b0;
            v2_r <= 1'b0;
        end else if (adder_en) begin
            if (adder_clr) begin
                v1_r <= 1'b0;
                v2_r <= 1'b0;
            end else begin
                v1_r <= accept_s;
                v2_r <= v1_r;
            end
        end
    end

    // Capture flag: a stalled stage-2 result is pushed once, then held off until the pipe moves.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_r <= 1'b0;
        end else if (adder_en) begin
            cap_r <= 1'b0;
        end else if (push_s) begin
            cap_r <= 1'b1;
        end
    end

    // Credit check from registered state only, so issue_rdy never depends on issue_vld.
    always_comb begin
        inflight_s    = inflight_cnt(v1_r, v2_r, cap_r);
        credit_used_s = {1'b0, count_s} + (CW+1)'(inflight_s);
        if (credit_used_s < DEPTH_C) begin
            issue_rdy = 1'b1;
        end else begin
            issue_rdy = 1'b0;
        end
    end

    assign wdata_s = {add_ovf, add_out};

    adder_rsp_fifo #(
        .DEPTH (DEPTH),
        .W     (DW + 1)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (wdata_s),
        .rdata (rdata_s),
        .empty (empty_s),
        .count (count_s)
    );

    assign rsp_vld  = ~empty_s;
    assign rsp_data = rdata_s[DW-1:0];
    assign rsp_ovf  = rdata_s[DW];
    assign level    = count_s;

`ifdef ADDER_RSP_OVF_CNT_EN
    logic [15:0] ovf_cnt_r;

    // Saturating count of consumed results that carried an overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_cnt_r <= 16'h0000;
        end else if (pop_s && rsp_ovf && (ovf_cnt_r != 16'hFFFF)) begin
            ovf_cnt_r <= ovf_cnt_r + 16'h0001;
        end
    end

    assign ovf_cnt = ovf_cnt_r;
`endif

endmodule

// File: tb/tb_adder_rsp_buf.sv
// Scoreboard bench for adder_rsp_buf with a stand-in two-stage adder.
module tb_adder_rsp_buf;

    localparam int DEPTH = 4;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          adder_en = 1'b1;
    logic          adder_clr = 1'b0;
    logic          issue_vld = 1'b0;
    logic          issue_rdy;
    logic [DW-1:0] in1 = '0;
    logic [DW-1:0] in2 = '0;
    logic [DW-1:0] add_out = '0;
    logic          add_ovf = 1'b0;
    logic          rsp_vld;
    logic          rsp_rdy = 1'b1;
    logic [DW-1:0] rsp_data;
    logic          rsp_ovf;
    logic [2:0]    level;
`ifdef ADDER_RSP_OVF_CNT_EN
    logic [15:0]   ovf_cnt;
`endif

    always #5 clk = ~clk;

    adder_rsp_buf #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .adder_en  (adder_en),
        .adder_clr (adder_clr),
        .issue_vld (issue_vld),
        .issue_rdy (issue_rdy),
        .add_out   (add_out),
        .add_ovf   (add_ovf),
        .rsp_vld   (rsp_vld),
        .rsp_rdy   (rsp_rdy),
        .rsp_data  (rsp_data),
        .rsp_ovf   (rsp_ovf),
`ifdef ADDER_RSP_OVF_CNT_EN
        .ovf_cnt   (ovf_cnt),
`endif
        .level     (level)
    );

    function automatic bit ovf_of(input logic [31:0] a, input logic [31:0] b);
        longint s;
        s = longint'($signed(a)) + longint'($signed(b));
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endfunction

    // Stand-in for the real adder: operand stage, then sum stage.
    logic [DW-1:0] s1_a = '0;
    logic [DW-1:0] s1_b = '0;
    always @(posedge clk) begin
        if (adder_en) begin
            if (adder_clr) begin
                s1_a <= '0; s1_b <= '0; add_out <= '0; add_ovf <= 1'b0;
            end else begin
                s1_a <= in1; s1_b <= in2;
                add_out <= s1_a + s1_b; add_ovf <= ovf_of(s1_a, s1_b);
            end
        end
    end

    // Reference model: results in flight by age, and results owed to the consumer.
    typedef struct packed { logic ovf; logic [31:0] data; } rsp_t;
    typedef struct { rsp_t r; int age; } fly_t;
    rsp_t exp_q[$];
    fly_t fly_q[$];
    bit   accept_cur = 1'b0;
    rsp_t acc_item;
    int   ovf_model = 0;
    int   total = 0;
    int   bad = 0;
    bit   checking = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_rdy();
        return (exp_q.size() + fly_q.size()) < DEPTH;
    endfunction

    task automatic model_update();
        if (rst) begin
            exp_q.delete();
            fly_q.delete();
            ovf_model = 0;
        end else begin
            // A result that has reached the second stage is owed exactly once.
            while (fly_q.size() > 0 && fly_q[0].age == 2) begin
                exp_q.push_back(fly_q[0].r);
                void'(fly_q.pop_front());
            end
            if (adder_en) begin
                if (adder_clr) begin
                    fly_q.delete();
                end else begin
                    foreach (fly_q[i]) fly_q[i].age++;
                    if (accept_cur) fly_q.push_back('{r: acc_item, age: 1});
                end
            end
        end
    endtask

    task automatic step(input bit vld, input bit en, input bit clr, input bit rdy, input bit r,
                        input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1 model_update();
        #1;
        rst = r; adder_en = en; adder_clr = clr; rsp_rdy = rdy;
        issue_vld = vld; in1 = a; in2 = b;
        accept_cur = vld && en && !r && model_rdy();
        acc_item = '{ovf: ovf_of(a, b), data: a + b};
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, rdy, 1'b0, 32'h0, 32'h0);
    endtask

    // Monitor: compares DUT outputs against the model, pops on each handshake.
    always @(negedge clk) begin
        if (checking) begin
            check("level", 64'(level), 64'(exp_q.size()));
            check("issue_rdy", 64'(issue_rdy), 64'(model_rdy()));
            check("rsp_vld", 64'(rsp_vld), 64'(exp_q.size() > 0));
`ifdef ADDER_RSP_OVF_CNT_EN
            check("ovf_cnt", 64'(ovf_cnt), 64'(ovf_model));
`endif
            if (rsp_vld && exp_q.size() > 0) begin
                check("rsp_data", 64'(rsp_data), 64'(exp_q[0].data));
                check("rsp_ovf", 64'(rsp_ovf), 64'(exp_q[0].ovf));
                if (rsp_rdy) begin
                    if (exp_q[0].ovf && ovf_model < 65535) ovf_model++;
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        checking = 1'b1;
        check("rst_data", 64'(rsp_data), 64'h0);
        check("rst_ovf", 64'(rsp_ovf), 64'h0);
        check("rst_rdy", 64'(issue_rdy), 64'h1);

        // Single issue: response visible three cycles later.
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0001_FFFF, 32'h0000_0001);
        idle(2, 1'b1);
        check("lat_vld_early", 64'(rsp_vld), 64'h0);
        idle(1, 1'b1);
        check("lat_vld", 64'(rsp_vld), 64'h1);
        check("lat_data", 64'(rsp_data), 64'h0002_0000);
        idle(3, 1'b1);

        // Stall after stage 2: one push only.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'h0000_0020);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("stall_level", 64'(level), 64'h1);
        idle(3, 1'b1);

        // Back-to-back issue with the consumer stalled.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'(i * 3 + 1), 32'(i + 100));
        idle(3, 1'b0);
        check("full_level", 64'(level), 64'h4);
        check("full_rdy", 64'(issue_rdy), 64'h0);
        idle(7, 1'b1);

        // Clear kills the in-flight result but keeps the queued one.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0005, 32'h0000_0006);
        idle(3, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0007, 32'h0000_0008);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        idle(4, 1'b0);
        check("clr_level", 64'(level), 64'h1);
        check("clr_data", 64'(rsp_data), 64'h0000_000B);
        idle(3, 1'b1);

        // Signed overflow result.
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001);
        idle(3, 1'b0);
        check("ovf_flag", 64'(rsp_ovf), 64'h1);
        idle(2, 1'b1);
`ifdef ADDER_RSP_OVF_CNT_EN
        check("ovf_cnt_one", 64'(ovf_cnt), 64'h1);
`endif

        // Reset with results queued and in flight.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'(i + 40), 32'h0000_0001);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("rst_mid_level", 64'(level), 64'h0);
        check("rst_mid_vld", 64'(rsp_vld), 64'h0);
        check("rst_mid_rdy", 64'(issue_rdy), 64'h1);
        idle(4, 1'b0);
        check("rst_no_late", 64'(level), 64'h0);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            logic [31:0] a, b;
            a = $urandom();
            b = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFF0 : 32'($urandom());
            step($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 8, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 9) < 6, $urandom_range(0, 99) == 0, a, b);
        end
        idle(10, 1'b1);
        check("drain_level", 64'(level), 64'h0);

        @(negedge clk);
        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
